// File: rtl/add_sched_pkg.sv
// Shared definitions for the CV-X-IF add coprocessor scheduler: opcode decode
// constants, per-entry metadata and the execute FSM states.
package add_sched_pkg;

    localparam logic [31:0] OPC_MATCH = 32'h0000_002B;
    localparam logic [31:0] OPC_MASK  = 32'h0000_007F;
    localparam int          CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESULT
    } sched_state_e;

    // Width-independent part of a queue entry; id and operands live beside it
    // because their widths follow the module parameters.
    typedef struct packed {
        logic [4:0] rd;
        logic       committed;
        logic       killed;
    } entry_meta_t;

    function automatic logic is_copro(input logic [31:0] instr);
        return (instr & OPC_MASK) == OPC_MATCH;
    endfunction

endpackage

// File: rtl/add_sched_fifo.sv
// In-order instruction queue for the add coprocessor, with a commit-by-id
// port that tags every live entry carrying the committed id.
module add_sched_fifo
    import add_sched_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IdWidth = 3,
    parameter int Depth   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [IdWidth-1:0] push_id_i,
    input  logic [4:0]         push_rd_i,
    input  logic [XLEN-1:0]    push_rs1_i,
    input  logic [XLEN-1:0]    push_rs2_i,
    input  logic               pop_i,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [IdWidth-1:0] head_id_o,
    output logic [4:0]         head_rd_o,
    output logic [XLEN-1:0]    head_rs1_o,
    output logic [XLEN-1:0]    head_rs2_o,
    output logic               head_committed_o,
    output logic               head_killed_o
);

    localparam int PtrW = $clog2(Depth);

    logic [PtrW:0]      wptr_q, rptr_q;
    logic [PtrW-1:0]    widx, ridx;
    logic [Depth-1:0]   vld_q;
    logic [IdWidth-1:0] id_q  [Depth];
    logic [XLEN-1:0]    rs1_q [Depth];
    logic [XLEN-1:0]    rs2_q [Depth];
    entry_meta_t        meta_q[Depth];
    logic               do_push, do_pop, push_hit;

    assign widx    = wptr_q[PtrW-1:0];
    assign ridx    = rptr_q[PtrW-1:0];
    assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) && (widx == ridx);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    // A commit arriving with the push of its own id must not be lost.
    assign push_hit = commit_valid_i && (commit_id_i == push_id_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            vld_q  <= '0;
            for (int i = 0; i < Depth; i++) meta_q[i] <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (commit_valid_i && vld_q[i] && id_q[i] == commit_id_i) begin
                    meta_q[i].committed <= 1'b1;
                    meta_q[i].killed    <= commit_kill_i;
                end
            end
            if (do_push) begin
                vld_q[widx]  <= 1'b1;
                id_q[widx]   <= push_id_i;
                rs1_q[widx]  <= push_rs1_i;
                rs2_q[widx]  <= push_rs2_i;
                meta_q[widx] <= '{rd: push_rd_i, committed: push_hit,
                                  killed: push_hit & commit_kill_i};
                wptr_q       <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                vld_q[ridx] <= 1'b0;
                rptr_q      <= rptr_q + 1'b1;
            end
        end
    end

    assign head_id_o        = id_q[ridx];
    assign head_rd_o        = meta_q[ridx].rd;
    assign head_rs1_o       = rs1_q[ridx];
    assign head_rs2_o       = rs2_q[ridx];
    assign head_committed_o = vld_q[ridx] & meta_q[ridx].committed;
    assign head_killed_o    = meta_q[ridx].killed;

endmodule

// File: rtl/add_copro_sched.sv
// Issue/commit/result scheduler for the CV-X-IF example add coprocessor.
// Define CVXIF_ADD_SATURATE_EN for a signed-saturating sum instead of wrap-around.
module add_copro_sched
    import add_sched_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int IdWidth     = 3,
    parameter int Depth       = 4,
    parameter int ExecLatency = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic               result_we_o,
    output logic               busy_o
);

    logic               match, push, pop, full, empty;
    logic               head_committed, head_killed;
    logic [IdWidth-1:0] head_id;
    logic [4:0]         head_rd;
    logic [XLEN-1:0]    head_rs1, head_rs2;
    sched_state_e       state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    op_a_q, op_b_q, sum;

    assign match             = is_copro(issue_instr_i);
    assign issue_ready_o     = ~full;
    assign issue_accept_o    = issue_valid_i & match;
    assign issue_writeback_o = issue_valid_i & match;
    assign push              = issue_valid_i & issue_ready_o & match;
    assign pop = (state_q == IDLE && !empty && head_committed && head_killed) ||
                 (state_q == RESULT && result_ready_i);
    assign busy_o = ~empty | (state_q != IDLE);

    add_sched_fifo #(
        .XLEN    (XLEN),
        .IdWidth (IdWidth),
        .Depth   (Depth)
    ) u_fifo (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .push_i           (push),
        .push_id_i        (issue_id_i),
        .push_rd_i        (issue_instr_i[11:7]),
        .push_rs1_i       (issue_rs1_i),
        .push_rs2_i       (issue_rs2_i),
        .pop_i            (pop),
        .commit_valid_i   (commit_valid_i),
        .commit_id_i      (commit_id_i),
        .commit_kill_i    (commit_kill_i),
        .full_o           (full),
        .empty_o          (empty),
        .head_id_o        (head_id),
        .head_rd_o        (head_rd),
        .head_rs1_o       (head_rs1),
        .head_rs2_o       (head_rs2),
        .head_committed_o (head_committed),
        .head_killed_o    (head_killed)
    );

`ifdef CVXIF_ADD_SATURATE_EN
    logic [XLEN:0] wide;
    assign wide = {op_a_q[XLEN-1], op_a_q} + {op_b_q[XLEN-1], op_b_q};
    // Sign bits of the extended sum disagree only on signed overflow.
    always_comb begin
        sum = wide[XLEN-1:0];
        if (wide[XLEN] != wide[XLEN-1])
            sum = wide[XLEN] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
    end
`else
    assign sum = op_a_q + op_b_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            result_valid_o <= 1'b0;
            result_we_o    <= 1'b0;
            result_id_o    <= '0;
            result_rd_o    <= '0;
            result_data_o  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty && head_committed && !head_killed) begin
                        op_a_q  <= head_rs1;
                        op_b_q  <= head_rs2;
                        cnt_q   <= CNT_W'(ExecLatency - 1);
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        result_data_o  <= sum;
                        result_id_o    <= head_id;
                        result_rd_o    <= head_rd;
                        result_valid_o <= 1'b1;
                        result_we_o    <= 1'b1;
                        state_q        <= RESULT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESULT: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        result_we_o    <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
